// File: rtl/sal_rw_arbiter.sv
// sal_rw_arbiter
//   Chooses the data-bus direction between the AXI read (AR) and write (AW)
//   request streams and forwards one registered command per cycle to the
//   DDR2 command scheduler. Reads have priority. Write mode is forced once
//   enough writes pile up (WR_HI) and left once they drain (WR_LO) or a
//   read has waited too long (STARVE_MAX). Every direction change inserts
//   at least TURN idle cycles so DQ turnaround is paid in one lump.
//
// Ports
//   clk, rst_n        clock; asynchronous active-high reset
//   rd_*              read request stream (valid/ready, addr, id, len)
//   wr_*              write request stream (valid/ready, addr, id, len)
//   wr_pend_cnt       writes buffered upstream, head included
//   cmd_*             registered command stream to the scheduler
//   mode_write        direction is write (WRITE or TURN_TO_WR)
//   turn_busy         a turnaround is in progress
module sal_rw_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 4,
  parameter int WR_HI      = 6,
  parameter int WR_LO      = 2,
  parameter int STARVE_MAX = 16,
  parameter int TURN       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ID_W-1:0]   rd_id,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [CNT_W-1:0]  wr_pend_cnt,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [ID_W-1:0]   cmd_id,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              mode_write,
  output logic              turn_busy
);

  typedef enum logic [1:0] {
    ST_READ       = 2'd0,
    ST_TURN_TO_WR = 2'd1,
    ST_WRITE      = 2'd2,
    ST_TURN_TO_RD = 2'd3
  } state_t;

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]  STARVE_SAT = SC_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] WR_HI_C    = CNT_W'(WR_HI);
  localparam logic [CNT_W-1:0] WR_LO_C    = CNT_W'(WR_LO);
  localparam logic [3:0]       TURN_C     = 4'(TURN);

  state_t            state_reg, state_next;
  logic [3:0]        turn_cnt_reg, turn_cnt_next;
  logic [SC_W-1:0]   starve_cnt_reg, starve_cnt_next;

  logic              cmd_valid_reg;
  logic              cmd_write_reg;
  logic [ADDR_W-1:0] cmd_addr_reg;
  logic [ID_W-1:0]   cmd_id_reg;
  logic [LEN_W-1:0]  cmd_len_reg;

  logic slot_free;
  logic sw_to_wr;
  logic sw_to_rd;
  logic rd_hs;
  logic wr_hs;
  logic turn_done;
  logic [3:0] turn_dec;

  // The output register can take a new command if it is empty or its
  // current command is leaving this cycle.
  assign slot_free = ~cmd_valid_reg | cmd_ready;

  assign sw_to_wr = (state_reg == ST_READ) &
                    ((wr_pend_cnt >= WR_HI_C) | (~rd_valid & wr_valid));

  // Starvation is checked independently of WR_HI so a saturated read wait
  // always wins over a deep write backlog.
  assign sw_to_rd = (state_reg == ST_WRITE) & rd_valid &
                    ((wr_pend_cnt <= WR_LO_C) |
                     (starve_cnt_reg == STARVE_SAT) |
                     ~wr_valid);

  // A pending switch beats a free slot: the request waits for the new mode.
  assign rd_ready = ~rst_n & (state_reg == ST_READ)  & slot_free & ~sw_to_wr;
  assign wr_ready = ~rst_n & (state_reg == ST_WRITE) & slot_free & ~sw_to_rd;

  assign rd_hs = rd_valid & rd_ready;
  assign wr_hs = wr_valid & wr_ready;

  assign turn_dec = (turn_cnt_reg == 4'd0) ? 4'd0 : turn_cnt_reg - 4'd1;

  // Leave a turnaround state on the edge where the counter reaches zero,
  // giving exactly TURN idle cycles, but only once the last command of the
  // old direction has left the output register.
  assign turn_done = (turn_cnt_reg <= 4'd1) & ~cmd_valid_reg;

  always_comb begin
    state_next    = state_reg;
    turn_cnt_next = turn_cnt_reg;
    case (state_reg)
      ST_READ: begin
        if (sw_to_wr) begin
          state_next    = ST_TURN_TO_WR;
          turn_cnt_next = TURN_C;
        end
      end
      ST_TURN_TO_WR: begin
        turn_cnt_next = turn_dec;
        if (turn_done) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (sw_to_rd) begin
          state_next    = ST_TURN_TO_RD;
          turn_cnt_next = TURN_C;
        end
      end
      ST_TURN_TO_RD: begin
        turn_cnt_next = turn_dec;
        if (turn_done) begin
          state_next = ST_READ;
        end
      end
      default: begin
        state_next    = ST_READ;
        turn_cnt_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (rd_hs || ((state_next == ST_READ) && (state_reg != ST_READ))) begin
      starve_cnt_next = '0;
    end else if (rd_valid && (state_reg != ST_READ) &&
                 (starve_cnt_reg != STARVE_SAT)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg      <= ST_READ;
      turn_cnt_reg   <= 4'd0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      turn_cnt_reg   <= turn_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Command output register. Only one of rd_hs / wr_hs can be true since
  // the two ready signals are tied to mutually exclusive states.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cmd_valid_reg <= 1'b0;
      cmd_write_reg <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_id_reg    <= '0;
      cmd_len_reg   <= '0;
    end else if (rd_hs) begin
      cmd_valid_reg <= 1'b1;
      cmd_write_reg <= 1'b0;
      cmd_addr_reg  <= rd_addr;
      cmd_id_reg    <= rd_id;
      cmd_len_reg   <= rd_len;
    end else if (wr_hs) begin
      cmd_valid_reg <= 1'b1;
      cmd_write_reg <= 1'b1;
      cmd_addr_reg  <= wr_addr;
      cmd_id_reg    <= wr_id;
      cmd_len_reg   <= wr_len;
    end else if (cmd_ready) begin
      cmd_valid_reg <= 1'b0;
    end
  end

  assign cmd_valid  = cmd_valid_reg;
  assign cmd_write  = cmd_write_reg;
  assign cmd_addr   = cmd_addr_reg;
  assign cmd_id     = cmd_id_reg;
  assign cmd_len    = cmd_len_reg;

  assign mode_write = (state_reg == ST_WRITE) | (state_reg == ST_TURN_TO_WR);
  assign turn_busy  = (state_reg == ST_TURN_TO_WR) | (state_reg == ST_TURN_TO_RD);

endmodule

// File: doc/sal_rw_arbiter.md
Name: sal_rw_arbiter

Overview:
- Read/write direction arbiter between the AXI front end and the DDR2 command scheduler.
- Inputs: one read request stream (from AR) and one write request stream (from AW, data already buffered).
- Emits a single registered command stream to the scheduler.
- Read-priority with write-drain watermarks, a read-starvation limit, and enforced idle turnaround cycles on every direction change, to amortise DQ bus turnaround.

Parameters:
ADDR_W, 32, request address width
ID_W, 4, AXI ID width
LEN_W, 4, burst length field width
CNT_W, 4, width of write-pending count
WR_HI, 6, write-pending count at/above which arbiter forces write mode
WR_LO, 2, write-pending count at/below which write mode may be left for pending reads
STARVE_MAX, 16, cycles a pending read may wait before write mode is forcibly left
TURN, 2, idle cycles inserted on each direction change (legal range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
rd_valid  in  1  read request valid
rd_ready  out  1  read request accepted
rd_addr  in  ADDR_W  read address
rd_id  in  ID_W  read ID
rd_len  in  LEN_W  read burst length
wr_valid  in  1  write request valid
wr_ready  out  1  write request accepted
wr_addr  in  ADDR_W  write address
wr_id  in  ID_W  write ID
wr_len  in  LEN_W  write burst length
wr_pend_cnt  in  CNT_W  writes buffered upstream (including head)
cmd_valid  out  1  command valid
cmd_ready  in  1  scheduler accepts command
cmd_write  out  1  1=write, 0=read
cmd_addr  out  ADDR_W  command address
cmd_id  out  ID_W  command ID
cmd_len  out  LEN_W  command length
mode_write  out  1  state is WRITE or TURN_TO_WR
turn_busy  out  1  state is TURN_TO_WR or TURN_TO_RD

Behaviour:
- Reset (asynchronous, active-high): state=READ, cmd_valid=0, cmd_write/addr/id/len=0, starve_cnt=0, turn_cnt=0; rd_ready=wr_ready=0 while reset asserted.
- Output register:
  - "slot free" = ~cmd_valid | cmd_ready.
  - cmd_* holds stable while cmd_valid & ~cmd_ready.
  - Load on the accepted handshake; cmd_valid rises the cycle after rd/wr handshake. Latency 1.
  - Back-to-back handshakes give one command per cycle.
  - cmd_valid drops after cmd_ready when no new load occurs.
- rd_ready = (state==READ) & slot free & ~sw_to_wr.
- wr_ready = (state==WRITE) & slot free & ~sw_to_rd.
- Never both ready in one cycle.
- States READ, TURN_TO_WR, WRITE, TURN_TO_RD.
- READ:
  - sw_to_wr = (wr_pend_cnt>=WR_HI) | (~rd_valid & wr_valid).
  - If sw_to_wr: go to TURN_TO_WR, turn_cnt=TURN; no read accepted that cycle.
  - Neither valid: stay in READ.
- TURN_TO_WR:
  - turn_cnt decrements each cycle to 0 (saturating).
  - Enter WRITE when turn_cnt==0 and cmd_valid==0, i.e. the last read command has drained.
  - Dwell time is max(TURN, drain time).
- WRITE:
  - sw_to_rd = rd_valid & ((wr_pend_cnt<=WR_LO) | (starve_cnt==STARVE_MAX) | ~wr_valid).
  - If sw_to_rd: go to TURN_TO_RD, turn_cnt=TURN; no write accepted that cycle.
  - Neither valid: stay in WRITE.
- TURN_TO_RD: symmetric to TURN_TO_WR, exiting to READ.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle rd_valid=1 & state!=READ.
  - Cleared on any rd handshake and on entering READ.
  - Starvation overrides WR_HI: in WRITE, a saturated starve_cnt forces TURN_TO_RD even when wr_pend_cnt>=WR_HI.
- Hysteresis: READ→WRITE only on sw_to_wr; WRITE does not leave on count alone while wr_pend_cnt>WR_LO and no starvation.
- Simultaneous switch condition and slot-free: the switch wins and the request stays pending.
- Reset mid-command: cmd_valid clears immediately and the pending command is dropped; upstream re-issues.

Test Plan:
- Reads only (8 back-to-back, cmd_ready=1) -> 8 cmd_valid cycles, cmd_write=0, first cmd 1 cycle after first rd handshake, no bubbles, wr_ready=0 throughout.
- Reads streaming, wr_pend_cnt steps 5→6 -> rd_ready drops that cycle; cmd_valid low ≥2 cycles; next cmd has cmd_write=1; mode_write=1 and turn_busy=1 for 2 cycles.
- In WRITE with wr_pend_cnt=5, rd_valid=1 held -> stays WRITE until starve_cnt=16, then TURN_TO_RD, first read cmd ≤ 2 cycles after turn ends.
- In WRITE, wr_pend_cnt drops to 2 with rd_valid=1 -> switch to read after 2 idle cycles; with rd_valid=0 -> remains WRITE.
- cmd_ready held low 5 cycles with cmd_valid=1 -> cmd_addr/id/len/write stable; rd_ready=wr_ready=0; TURN_TO_WR exit deferred until drain even after turn_cnt=0.
- rst_n asserted mid-burst with cmd_valid=1 -> cmd_valid=0 same cycle asynchronously, state READ, starve_cnt=0 after release.
